tanh_lut_sequencer: RTL and testbench
=====================================

// Module: tanh_lut_sequencer
// PURPOSE
//  Front end of the per-layer tanh/sigmoid approximators in the LSTM datapath.
//  - Accepts one signed fixed-point activation input.
//  - Splits it into a table index and a fractional remainder.
//  - Reads two adjacent samples from a synchronous single-port function ROM.
//  - Presents base/next__data/change/remaining, held stable, to the
//    combinational linear interpolator under a valid/ready handshake.
// PARAMETERS
//  DATA_W      8   width of x, of ROM samples and of every output
//  FRAC_W      4   fractional bits of x; must match the interpolator's shift
//  ADDR_W      4   ROM address width
//  TABLE_DEPTH 16  ROM entries; equals 2**ADDR_W; entry DEPTH/2 is x=0
// PORTS
//  clk                 in   1        single clock; all state updates on rising edge
//  rst                 in   1        asynchronous, active-low reset
//  in_valid            in   1        x is valid
//  in_ready            out  1        block can accept x
//  x                   in   DATA_W   signed input, Q(DATA_W-FRAC_W).FRAC_W
//  rom_en              out  1        ROM read enable
//  rom_addr            out  ADDR_W   ROM read address
//  rom_data            in   DATA_W   signed ROM sample; valid the cycle after the sampling edge
//  out_valid           out  1        outputs below are valid
//  out_ready           in   1        interpolator/consumer takes the outputs
//  base                out  DATA_W   signed sample at idx
//  next__data          out  DATA_W   signed sample at idx+1 (clamped)
//  change              out  DATA_W   next__data - base, truncated to DATA_W
//  remaining           out  DATA_W   x[FRAC_W-1:0], zero-extended
// BEHAVIOUR
//  Reset (rst=0, asynchronous)
//  - state=IDLE; in_ready=1.
//  - rom_en=0, rom_addr=0, out_valid=0.
//  - base, next__data, change, remaining = 0.
//  - Reset mid-operation aborts the transaction; no output is produced for it.
//  Address arithmetic
//  - idx = x >>> FRAC_W (arithmetic shift).
//  - a0 = idx + DEPTH/2, mod 2**ADDR_W; range 0..DEPTH-1.
//  - a1 = a0+1, except a1 = a0 when a0 == DEPTH-1 (top-end clamp).
//  - At the clamp: next__data = base and change = 0.
//  States (one transition per edge)
//  - IDLE: in_ready=1. On in_valid: latch x and remaining; rom_addr<=a0; rom_en<=1; go to RD_BASE.
//  - RD_BASE: ROM samples a0. rom_addr<=a1; go to RD_NEXT.
//  - RD_NEXT: base<=rom_data; ROM samples a1; rom_en<=0; go to CAPT.
//  - CAPT: next__data<=rom_data; change<=rom_data-base; out_valid<=1; go to OUT.
//  - OUT: hold every output stable while out_ready=0. On out_ready: out_valid<=0; go to IDLE.
//  Latency and throughput
//  - out_valid rises on the 4th edge after the accepting edge.
//  - Minimum 5 cycles per transaction.
//  Handshake
//  - in_ready is low in every state except IDLE; in_valid there is ignored and x is not sampled.
//  - in_ready returns on the edge that completes the output transfer.
//  - That edge never also accepts a new x.
//  - out_valid, once high, is never dropped before out_ready.
//  - rom_data is ignored outside RD_NEXT/CAPT.
//  Output transfer
//  - base/next__data/change/remaining change only in RD_NEXT/CAPT or on reset.
// TESTING  (bench ROM: table[a] = 8*a - 64, signed; 1-cycle read latency)
//  1. x=0x00, out_ready=1 -> addr 8 then 9; base=0, next__data=8, change=8,
//     remaining=0; out_valid on 4th edge after accept.
//  2. x=0x35 -> addr 11,12; base=24, next__data=32, change=8, remaining=5.
//  3. x=0x7F -> addr 15,15 (clamp); base=56, next__data=56, change=0, remaining=15.
//  4. x=0x80 -> addr 0,1; base=-64, next__data=-56, change=8, remaining=0.
//  5. out_ready=0 for 10 cycles after out_valid -> outputs/out_valid stable;
//     in_valid pulses with x=0x10 during busy ignored; after out_ready, next
//     accepted x is sampled in IDLE only.
//  6. rst low in RD_NEXT -> all outputs 0 immediately; no out_valid; a new x
//     after release is processed correctly (repeat scenario 2).

Source files
------------

// File: rtl/tanh_lut_sequencer.sv
// +------------------------------------------------------------------------+
// | tanh_lut_sequencer                                                     |
// | Splits a fixed-point activation into a table index and remainder,      |
// | fetches two adjacent ROM samples and presents them to the interpolator.|
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

module tanh_lut_sequencer #(
  parameter int DATA_W      = 8,
  parameter int FRAC_W      = 4,
  parameter int ADDR_W      = 4,
  parameter int TABLE_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] base,
  output logic [DATA_W-1:0] next__data,
  output logic [DATA_W-1:0] change,
  output logic [DATA_W-1:0] remaining
);

  localparam logic [ADDR_W-1:0] c_half = ADDR_W'(TABLE_DEPTH / 2);
  localparam logic [ADDR_W-1:0] c_top  = ADDR_W'(TABLE_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_BASE = 3'd1,
    S_RD_NEXT = 3'd2,
    S_CAPT    = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [FRAC_W-1:0]   r_frac, w_frac_nxt;
  logic                r_clamp, w_clamp_nxt;
  logic                w_rom_en_nxt;
  logic [ADDR_W-1:0]   w_rom_addr_nxt;
  logic                w_out_valid_nxt;
  logic [DATA_W-1:0]   w_base_nxt, w_next_nxt, w_change_nxt, w_rem_nxt;

  // Entry DEPTH/2 holds x=0, so the signed index is offset by half the table.
  function automatic logic [ADDR_W-1:0] f_addr0(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] idx;
    idx = $signed(v) >>> FRAC_W;
    return idx[ADDR_W-1:0] + c_half;
  endfunction

  assign in_ready = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_frac_nxt      = r_frac;
    w_clamp_nxt     = r_clamp;
    w_rom_en_nxt    = rom_en;
    w_rom_addr_nxt  = rom_addr;
    w_out_valid_nxt = out_valid;
    w_base_nxt      = base;
    w_next_nxt      = next__data;
    w_change_nxt    = change;
    w_rem_nxt       = remaining;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_frac_nxt     = x[FRAC_W-1:0];
          w_rom_addr_nxt = f_addr0(x);
          w_rom_en_nxt   = 1'b1;
          w_state_nxt    = S_RD_BASE;
        end
      end
      S_RD_BASE: begin
        w_clamp_nxt    = (rom_addr == c_top);
        w_rom_addr_nxt = (rom_addr == c_top) ? rom_addr : rom_addr + 1'b1;
        w_state_nxt    = S_RD_NEXT;
      end
      S_RD_NEXT: begin
        w_base_nxt   = rom_data;
        w_rem_nxt    = {{(DATA_W-FRAC_W){1'b0}}, r_frac};
        w_rom_en_nxt = 1'b0;
        w_state_nxt  = S_CAPT;
      end
      S_CAPT: begin
        // At the top of the table both taps are the same sample.
        if (r_clamp) begin
          w_next_nxt   = base;
          w_change_nxt = '0;
        end else begin
          w_next_nxt   = rom_data;
          w_change_nxt = rom_data - base;
        end
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frac     <= '0;
      r_clamp    <= 1'b0;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      out_valid  <= 1'b0;
      base       <= '0;
      next__data <= '0;
      change     <= '0;
      remaining  <= '0;
    end else begin
      r_frac     <= w_frac_nxt;
      r_clamp    <= w_clamp_nxt;
      rom_en     <= w_rom_en_nxt;
      rom_addr   <= w_rom_addr_nxt;
      out_valid  <= w_out_valid_nxt;
      base       <= w_base_nxt;
      next__data <= w_next_nxt;
      change     <= w_change_nxt;
      remaining  <= w_rem_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tanh_lut_sequencer.sv
// +------------------------------------------------------------------------+
// | tb_tanh_lut_sequencer                                                  |
// | Directed bench with a transaction-level reference model and ROM.       |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_tanh_lut_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] x;
  logic       rom_en;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       out_valid, out_ready;
  logic [7:0] base, next__data, change, remaining;

  int n_chk  = 0;
  int n_fail = 0;

  tanh_lut_sequencer #(
    .DATA_W(8), .FRAC_W(4), .ADDR_W(4), .TABLE_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .base(base), .next__data(next__data), .change(change), .remaining(remaining)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, table[a] = 8*a - 64, one cycle read latency
  initial rom_data = '0;
  always @(posedge clk) if (rom_en) rom_data <= 8'(8 * int'(rom_addr) - 64);

  typedef struct packed {
    logic [3:0] a0, a1;
    logic [7:0] base, nxt, chg, rem;
  } exp_t;

  function automatic exp_t f_model(input logic [7:0] xv);
    exp_t e;
    int xi, idx, a0, a1, b, n;
    xi  = int'($signed(xv));
    idx = (xi >= 0) ? xi / 16 : -((-xi + 15) / 16);
    a0  = idx + 8;
    a1  = (a0 == 15) ? 15 : a0 + 1;
    b   = 8 * a0 - 64;
    n   = 8 * a1 - 64;
    e.a0   = 4'(a0);
    e.a1   = 4'(a1);
    e.base = 8'(b);
    e.nxt  = 8'(n);
    e.chg  = 8'(n - b);
    e.rem  = 8'(xi & 15);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: busy from the accepting edge; t counts edges since then.
  logic m_busy;
  int   m_t;
  exp_t m_cur, m_last;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_t    <= 0;
      m_cur  <= '0;
      m_last <= '0;
    end else if (m_busy) begin
      if (m_t >= 3 && out_ready) begin
        m_busy <= 1'b0;
        m_last <= m_cur;
      end else begin
        m_t <= m_t + 1;
      end
    end else if (in_valid) begin
      m_busy <= 1'b1;
      m_t    <= 0;
      m_cur  <= f_model(x);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_rom_en", 32'(rom_en), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_outputs", {base, next__data, change, remaining}, 32'd0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_busy && m_t >= 3));
      chk("rom_en", 32'(rom_en), 32'(m_busy && m_t <= 1));
      if (m_busy && m_t == 0) chk("rom_addr_a0", 32'(rom_addr), 32'(m_cur.a0));
      if (m_busy && m_t == 1) chk("rom_addr_a1", 32'(rom_addr), 32'(m_cur.a1));
      if (m_busy && m_t >= 3)
        chk("outputs", {base, next__data, change, remaining},
            {m_cur.base, m_cur.nxt, m_cur.chg, m_cur.rem});
      else if (!m_busy)
        chk("held_outputs", {base, next__data, change, remaining},
            {m_last.base, m_last.nxt, m_last.chg, m_last.rem});
    end
  end

  // Accept one x, wait for out_valid and check it against literal values.
  task automatic do_txn(input logic [7:0] xv, input logic [7:0] eb, input logic [7:0] en,
                        input logic [7:0] ec, input logic [7:0] er);
    int n;
    @(negedge clk);
    chk("txn_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x        = xv;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    // Counting the accepting edge as the first, out_valid follows the 4th.
    chk("txn_latency", 32'(n), 32'd4);
    chk("txn_lit", {base, next__data, change, remaining}, {eb, en, ec, er});
  endtask

  initial begin
    exp_t e;
    int   n;
    rst = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b0;

    e = f_model(8'h00); chk("model_00", 32'(e), {8'd0, 4'd8, 4'd9, 8'd0, 8'd8, 8'd8, 8'd0});
    e = f_model(8'h35); chk("model_35", 32'(e), {8'd0, 4'd11, 4'd12, 8'd24, 8'd32, 8'd8, 8'd5});
    e = f_model(8'h7F); chk("model_7F", 32'(e), {8'd0, 4'd15, 4'd15, 8'd56, 8'd56, 8'd0, 8'd15});
    e = f_model(8'h80); chk("model_80", 32'(e), {8'd0, 4'd0, 4'd1, 8'hC0, 8'hC8, 8'd8, 8'd0});

    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;

    do_txn(8'h00, 8'd0,  8'd8,  8'd8, 8'd0);
    do_txn(8'h35, 8'd24, 8'd32, 8'd8, 8'd5);
    do_txn(8'h7F, 8'd56, 8'd56, 8'd0, 8'd15);
    do_txn(8'h80, 8'hC0, 8'hC8, 8'd8, 8'd0);

    // Back-pressure with ignored in_valid pulses while busy
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x         = 8'h20;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      in_valid = (n % 2 == 1);
      x        = 8'h10;
      n++;
    end
    chk("bp_latency", 32'(n), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      x        = 8'h10;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", {base, next__data, change, remaining}, {8'd16, 8'd24, 8'd8, 8'd0});
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = 8'h10;
    @(negedge clk);
    chk("bp_done_valid", 32'(out_valid), 32'd0);
    chk("bp_done_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_busy", 32'(in_ready), 32'd0);
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_next_latency", 32'(n), 32'd4);
    chk("bp_next_data", {base, next__data, change, remaining}, {8'd8, 8'd16, 8'd8, 8'd0});

    // Asynchronous reset while the second sample is being read
    @(negedge clk);
    in_valid = 1'b1;
    x        = 8'h35;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_outputs", {base, next__data, change, remaining}, 32'd0);
    chk("arst_ctrl", {31'd0, out_valid} | {30'd0, rom_en, 1'b0}, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    do_txn(8'h35, 8'd24, 8'd32, 8'd8, 8'd5);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
